// File: rtl/block_rx_buffer.sv
// Circular block queue with first-word-fall-through output and a registered hold with a one-block skid slot.
// Optional BLOCK_RX_DROPCNT_EN adds a saturating drop_count output.
module block_rx_buffer #(
  parameter int BSIZE = 128,
  parameter int DEPTH = 4,
  localparam int LVLW = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [BSIZE-1:0] block_in,
  input  logic             block_in_ready,
  output logic             block_in_hold,
  output logic [BSIZE-1:0] block_out,
  output logic             block_valid,
  input  logic             block_accept,
  output logic [LVLW-1:0]  level,
  output logic             overflow
`ifdef BLOCK_RX_DROPCNT_EN
  ,
  output logic [15:0]      drop_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [LVLW-1:0] FULL_LVL = LVLW'(DEPTH);
  localparam logic [LVLW-1:0] HOLD_LVL = LVLW'(DEPTH - 1);

  logic [BSIZE-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [LVLW-1:0]  level_r;
  logic             valid_r;
  logic             hold_r;
  logic             overflow_r;

  logic             push_s;
  logic             pop_s;
  logic             drop_s;
  logic [LVLW-1:0]  level_next_s;

  // Push/pop decisions and next occupancy; a strobe while full is only taken alongside a pop.
  always_comb begin
    pop_s        = 1'b0;
    push_s       = 1'b0;
    drop_s       = 1'b0;
    level_next_s = level_r;
    pop_s        = valid_r && block_accept;
    if (block_in_ready && ((level_r < FULL_LVL) || pop_s)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    drop_s = block_in_ready && !push_s;
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + LVLW'(1);
      2'b01:   level_next_s = level_r - LVLW'(1);
      default: level_next_s = level_r;
    endcase
  end

  // Block storage; contents are intentionally not cleared by reset.
  always_ff @(posedge clock) begin
    if (!reset && push_s) begin
      mem_r[wr_ptr_r] <= block_in;
    end
  end

  // Pointers, occupancy and status flags; hold anticipates the upstream one-cycle reaction lag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      level_r    <= {LVLW{1'b0}};
      valid_r    <= 1'b0;
      hold_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      level_r <= level_next_s;
      valid_r <= (level_next_s != {LVLW{1'b0}});
      hold_r  <= (level_next_s >= HOLD_LVL);
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Head of queue falls through; forced to zero while the queue is empty.
  always_comb begin
    block_out = {BSIZE{1'b0}};
    if (valid_r) begin
      block_out = mem_r[rd_ptr_r];
    end else begin
      block_out = {BSIZE{1'b0}};
    end
  end

  assign block_valid   = valid_r;
  assign block_in_hold = hold_r;
  assign level         = level_r;
  assign overflow      = overflow_r;

`ifdef BLOCK_RX_DROPCNT_EN
  logic [15:0] drop_cnt_r;

  // Saturating count of strobes lost while full.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt_r <= 16'h0000;
    end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'h0001;
    end
  end

  assign drop_count = drop_cnt_r;
`endif

endmodule

// File: tb/tb_block_rx_buffer.sv
// Table-driven directed bench for block_rx_buffer (BSIZE=128, DEPTH=4), plus a hand-written full/drop sequence.
module tb_block_rx_buffer;

  logic         clock;
  logic         reset;
  logic [127:0] block_in;
  logic         block_in_ready;
  logic         block_in_hold;
  logic [127:0] block_out;
  logic         block_valid;
  logic         block_accept;
  logic [2:0]   level;
  logic         overflow;
`ifdef BLOCK_RX_DROPCNT_EN
  logic [15:0]  drop_count;
`endif

  block_rx_buffer #(.BSIZE(128), .DEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .block_in       (block_in),
    .block_in_ready (block_in_ready),
    .block_in_hold  (block_in_hold),
    .block_out      (block_out),
    .block_valid    (block_valid),
    .block_accept   (block_accept),
    .level          (level)
`ifdef BLOCK_RX_DROPCNT_EN
    ,
    .drop_count     (drop_count)
`endif
    ,
    .overflow       (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         rst;
    logic         rdy;
    logic [127:0] din;
    logic         acc;
    logic [2:0]   lvl;
    logic         vld;
    logic         hold;
    logic         ovf;
    logic [127:0] out;
    logic [15:0]  dcnt;
  } vec_t;

  vec_t vecs[$];
  int   applied;
  int   miscompares;

  task automatic add(input logic rst, input logic rdy, input logic [127:0] din, input logic acc,
                     input logic [2:0] lvl, input logic vld, input logic hold, input logic ovf,
                     input logic [127:0] out, input logic [15:0] dcnt);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.din = din; v.acc = acc;
    v.lvl = lvl; v.vld = vld; v.hold = hold; v.ovf = ovf; v.out = out; v.dcnt = dcnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic apply_and_check(input vec_t v, input int idx);
    @(negedge clock);
    reset          = v.rst;
    block_in_ready = v.rdy;
    block_in       = v.din;
    block_accept   = v.acc;
    @(posedge clock);
    #1;
    applied++;
    chk("level", idx, 128'(level), 128'(v.lvl));
    chk("block_valid", idx, 128'(block_valid), 128'(v.vld));
    chk("block_in_hold", idx, 128'(block_in_hold), 128'(v.hold));
    chk("overflow", idx, 128'(overflow), 128'(v.ovf));
    if (v.vld || v.rst) begin
      chk("block_out", idx, block_out, v.out);
    end
`ifdef BLOCK_RX_DROPCNT_EN
    chk("drop_count", idx, 128'(drop_count), 128'(v.dcnt));
`endif
  endtask

  function automatic logic [127:0] pat(input logic [3:0] n);
    return {32{n}};
  endfunction

  localparam logic [127:0] ZERO = 128'h0;
  localparam logic [127:0] DEAD = 128'hDEAD;
  localparam logic [127:0] BEEF = 128'hBEEF;

  initial begin
    applied        = 0;
    miscompares    = 0;
    reset          = 1'b0;
    block_in_ready = 1'b0;
    block_in       = 128'h0;
    block_accept   = 1'b0;

    //   rst   rdy   din          acc    lvl   vld   hold  ovf   out          dcnt
    add(1'b1, 1'b0, ZERO,        1'b0, 3'd0, 1'b0, 1'b0, 1'b0, ZERO,        16'd0);
    add(1'b0, 1'b1, pat(4'h1),   1'b0, 3'd1, 1'b1, 1'b0, 1'b0, pat(4'h1),   16'd0);
    add(1'b0, 1'b1, pat(4'h2),   1'b0, 3'd2, 1'b1, 1'b0, 1'b0, pat(4'h1),   16'd0);
    add(1'b0, 1'b0, ZERO,        1'b0, 3'd2, 1'b1, 1'b0, 1'b0, pat(4'h1),   16'd0);
    add(1'b0, 1'b1, pat(4'h3),   1'b0, 3'd3, 1'b1, 1'b1, 1'b0, pat(4'h1),   16'd0);
    add(1'b0, 1'b1, pat(4'h4),   1'b0, 3'd4, 1'b1, 1'b1, 1'b0, pat(4'h1),   16'd0);
    add(1'b0, 1'b1, DEAD,        1'b0, 3'd4, 1'b1, 1'b1, 1'b1, pat(4'h1),   16'd1);
    add(1'b0, 1'b1, BEEF,        1'b1, 3'd4, 1'b1, 1'b1, 1'b1, pat(4'h2),   16'd1);
    add(1'b0, 1'b0, ZERO,        1'b1, 3'd3, 1'b1, 1'b1, 1'b1, pat(4'h3),   16'd1);
    add(1'b0, 1'b0, ZERO,        1'b1, 3'd2, 1'b1, 1'b0, 1'b1, pat(4'h4),   16'd1);
    add(1'b0, 1'b0, ZERO,        1'b1, 3'd1, 1'b1, 1'b0, 1'b1, BEEF,        16'd1);
    add(1'b0, 1'b0, ZERO,        1'b1, 3'd0, 1'b0, 1'b0, 1'b1, ZERO,        16'd1);
    add(1'b0, 1'b0, ZERO,        1'b1, 3'd0, 1'b0, 1'b0, 1'b1, ZERO,        16'd1);
    add(1'b1, 1'b0, ZERO,        1'b0, 3'd0, 1'b0, 1'b0, 1'b0, ZERO,        16'd0);
    // Streaming: each strobe is visible at the head one cycle later and popped the cycle after.
    for (int k = 0; k < 10; k++) begin
      add(1'b0, 1'b1, {4{32'hC000_0000 + 32'(k)}}, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0,
          {4{32'hC000_0000 + 32'(k)}}, 16'd0);
    end
    add(1'b0, 1'b0, ZERO,        1'b1, 3'd0, 1'b0, 1'b0, 1'b0, ZERO,        16'd0);
    // Reset in the middle of traffic with a strobe present.
    add(1'b0, 1'b1, pat(4'hA),   1'b0, 3'd1, 1'b1, 1'b0, 1'b0, pat(4'hA),   16'd0);
    add(1'b0, 1'b1, pat(4'hB),   1'b0, 3'd2, 1'b1, 1'b0, 1'b0, pat(4'hA),   16'd0);
    add(1'b0, 1'b1, pat(4'hC),   1'b0, 3'd3, 1'b1, 1'b1, 1'b0, pat(4'hA),   16'd0);
    add(1'b1, 1'b1, pat(4'hD),   1'b1, 3'd0, 1'b0, 1'b0, 1'b0, ZERO,        16'd0);
    add(1'b0, 1'b0, ZERO,        1'b0, 3'd0, 1'b0, 1'b0, 1'b0, ZERO,        16'd0);
    add(1'b0, 1'b1, pat(4'hE),   1'b0, 3'd1, 1'b1, 1'b0, 1'b0, pat(4'hE),   16'd0);
    add(1'b1, 1'b0, ZERO,        1'b0, 3'd0, 1'b0, 1'b0, 1'b0, ZERO,        16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_and_check(vecs[i], i);
    end

    // Hand sequence: fill to full, two lost strobes, head must stay put, then one pop.
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      reset          = 1'b0;
      block_in_ready = 1'b1;
      block_in       = pat(4'(k + 5));
      block_accept   = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      block_in_ready = 1'b1;
      block_in       = DEAD;
    end
    @(negedge clock);
    block_in_ready = 1'b0;
    applied++;
    chk("seq_full_level", 100, 128'(level), 128'(3'd4));
    chk("seq_full_overflow", 100, 128'(overflow), 128'(1'b1));
    chk("seq_full_head", 100, block_out, pat(4'h5));
`ifdef BLOCK_RX_DROPCNT_EN
    chk("seq_drop_count", 100, 128'(drop_count), 128'(16'd2));
`endif
    block_accept = 1'b1;
    @(negedge clock);
    block_accept = 1'b0;
    applied++;
    chk("seq_pop_level", 101, 128'(level), 128'(3'd3));
    chk("seq_pop_head", 101, block_out, pat(4'h6));
    chk("seq_pop_hold", 101, 128'(block_in_hold), 128'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
